// File: rtl/snake_pkg.sv
// ---------------------------------------------------------------------------
// snake_pkg
// Shared definitions for the snake body store:
//   - direction codes (LEFT/RIGHT/UP/DOWN) as carried on the 2-bit dir bus
//   - step sequencer state encoding
//   - opposite_dir(): the direction that would fold the snake onto itself
// ---------------------------------------------------------------------------
package snake_pkg;

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic logic [1:0] opposite_dir(input logic [1:0] d);
        logic [1:0] r;
        r = DIR_RIGHT;
        case (d)
            DIR_LEFT:  r = DIR_RIGHT;
            DIR_RIGHT: r = DIR_LEFT;
            DIR_UP:    r = DIR_DOWN;
            default:   r = DIR_UP;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// ---------------------------------------------------------------------------
// snake_next_head
// Combinational next-cell calculator. Moves the head one cell in eff_dir and
// flags a wall hit when that move would leave the 0..X_MAX / 0..Y_MAX field.
// On a wall hit next_x/next_y simply repeat the current head.
// Ports:
//   head_x, head_y   current head cell
//   eff_dir          filtered direction of travel
//   next_x, next_y   candidate new head cell
//   wall             move would leave the playing field
// ---------------------------------------------------------------------------
module snake_next_head
    import snake_pkg::*;
#(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic [X_W-1:0] head_x,
    input  logic [Y_W-1:0] head_y,
    input  logic [1:0]     eff_dir,
    output logic [X_W-1:0] next_x,
    output logic [Y_W-1:0] next_y,
    output logic           wall
);

    always_comb begin
        next_x = head_x;
        next_y = head_y;
        wall   = 1'b0;
        case (eff_dir)
            DIR_LEFT: begin
                if (head_x == '0) wall = 1'b1;
                else              next_x = head_x - X_W'(1);
            end
            DIR_RIGHT: begin
                if (head_x == X_W'(X_MAX)) wall = 1'b1;
                else                       next_x = head_x + X_W'(1);
            end
            DIR_UP: begin
                if (head_y == '0) wall = 1'b1;
                else              next_y = head_y - Y_W'(1);
            end
            default: begin
                if (head_y == Y_W'(Y_MAX)) wall = 1'b1;
                else                       next_y = head_y + Y_W'(1);
            end
        endcase
    end

endmodule

// File: rtl/snake_body_ring.sv
// ---------------------------------------------------------------------------
// snake_body_ring
// Snake body kept as a circular buffer of cells (tail_ptr = oldest,
// head_ptr = newest). A step is accepted in IDLE, its next head is computed
// and wall-checked, then CHECK walks the body one stored cell per cycle
// looking for a self collision, and COMMIT applies the move in one cycle.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   step, grow, dir      move request (grow keeps the tail), direction
//   clear                synchronous restart, same as reset
//   busy, done           step in flight / one-cycle completion pulse
//   head_x, head_y       current head cell
//   erase_valid/x/y      tail cell vacated by the last step (pulse with done)
//   hit_wall, hit_self   sticky collision flags, cleared only by reset/clear
//   length               current segment count
// ---------------------------------------------------------------------------
module snake_body_ring
    import snake_pkg::*;
#(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int MAX_LEN = 128,
    parameter int X_MAX   = 159,
    parameter int Y_MAX   = 119,
    parameter int INIT_X  = 0,
    parameter int INIT_Y  = 0
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       step,
    input  logic                       grow,
    input  logic [1:0]                 dir,
    input  logic                       clear,
    output logic                       busy,
    output logic                       done,
    output logic [X_W-1:0]             head_x,
    output logic [Y_W-1:0]             head_y,
    output logic                       erase_valid,
    output logic [X_W-1:0]             erase_x,
    output logic [Y_W-1:0]             erase_y,
    output logic                       hit_wall,
    output logic                       hit_self,
    output logic [$clog2(MAX_LEN):0]   length
);

    localparam int PW = $clog2(MAX_LEN);
    localparam int LW = PW + 1;
    localparam int EW = X_W + Y_W;

    // body storage: each entry is {x, y}
    logic [EW-1:0] mem [MAX_LEN];
    logic [EW-1:0] rd_data_reg;
    logic [PW-1:0] rd_addr;
    logic          wr_en;
    logic [PW-1:0] wr_addr;
    logic [EW-1:0] wr_data;

    state_t        state_reg, state_next;

    logic [PW-1:0]  head_ptr_reg, tail_ptr_reg;
    logic [LW-1:0]  length_reg;
    logic [X_W-1:0] head_x_reg, erase_x_reg, nx_reg;
    logic [Y_W-1:0] head_y_reg, erase_y_reg, ny_reg;
    logic [1:0]     last_dir_reg, dir_pend_reg;
    logic           hit_wall_reg, hit_self_reg;
    logic           done_reg, erase_valid_reg;
    logic           wall_pend_reg, self_pend_reg, grow_pend_reg;
    logic [PW-1:0]  scan_ptr_reg;
    logic [LW-1:0]  scan_cnt_reg;

    logic           restart;
    logic [1:0]     eff_dir;
    logic [X_W-1:0] nh_x;
    logic [Y_W-1:0] nh_y;
    logic           nh_wall;
    logic           grow_eff;
    logic [LW-1:0]  scan_n;
    logic [PW-1:0]  scan_first;
    logic           accept;
    logic           self_match;
    logic           scan_last;
    logic           commit_ok;

    assign restart = !resetn || clear;

    // a reversal would fold the head into its own neck; only a 1-cell
    // snake is allowed to turn around
    assign eff_dir = ((length_reg > LW'(1)) && (dir == opposite_dir(last_dir_reg)))
                     ? last_dir_reg : dir;

    snake_next_head #(
        .X_W   (X_W),
        .Y_W   (Y_W),
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_next_head (
        .head_x  (head_x_reg),
        .head_y  (head_y_reg),
        .eff_dir (eff_dir),
        .next_x  (nh_x),
        .next_y  (nh_y),
        .wall    (nh_wall)
    );

    // a grow at full length degenerates to a plain move
    assign grow_eff = grow && (length_reg < LW'(MAX_LEN));
    // on a plain move the tail cell is vacated, so the scan skips it and
    // starts at the second-oldest cell
    assign scan_n     = grow_eff ? length_reg : (length_reg - LW'(1));
    assign scan_first = grow_eff ? tail_ptr_reg : (tail_ptr_reg + PW'(1));

    assign accept     = (state_reg == ST_IDLE) && step && !hit_wall_reg && !hit_self_reg;
    assign self_match = (rd_data_reg == {nx_reg, ny_reg});
    assign scan_last  = (scan_cnt_reg == LW'(1));
    assign commit_ok  = (state_reg == ST_COMMIT) && !wall_pend_reg && !self_pend_reg;

    // Sequencer and read-address steering. The memory read is registered,
    // so the address presented in a cycle is the entry seen in the next.
    // The cycle before COMMIT always addresses the tail so its old value is
    // available for the erase report.
    always_comb begin
        state_next = state_reg;
        rd_addr    = tail_ptr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (nh_wall || (scan_n == '0)) begin
                        state_next = ST_COMMIT;
                    end else begin
                        state_next = ST_CHECK;
                        rd_addr    = scan_first;
                    end
                end
            end
            ST_CHECK: begin
                if (self_match || scan_last) begin
                    state_next = ST_COMMIT;
                end else begin
                    rd_addr = scan_ptr_reg + PW'(1);
                end
            end
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // restart seeds entry 0 with the start cell; otherwise COMMIT appends
    always_comb begin
        wr_en   = restart || commit_ok;
        wr_addr = restart ? '0 : (head_ptr_reg + PW'(1));
        wr_data = restart ? {X_W'(INIT_X), Y_W'(INIT_Y)} : {nx_reg, ny_reg};
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data_reg <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            state_reg       <= ST_IDLE;
            head_ptr_reg    <= '0;
            tail_ptr_reg    <= '0;
            length_reg      <= LW'(1);
            head_x_reg      <= X_W'(INIT_X);
            head_y_reg      <= Y_W'(INIT_Y);
            last_dir_reg    <= DIR_RIGHT;
            hit_wall_reg    <= 1'b0;
            hit_self_reg    <= 1'b0;
            done_reg        <= 1'b0;
            erase_valid_reg <= 1'b0;
            erase_x_reg     <= '0;
            erase_y_reg     <= '0;
            nx_reg          <= '0;
            ny_reg          <= '0;
            wall_pend_reg   <= 1'b0;
            self_pend_reg   <= 1'b0;
            grow_pend_reg   <= 1'b0;
            dir_pend_reg    <= DIR_RIGHT;
            scan_ptr_reg    <= '0;
            scan_cnt_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            done_reg        <= 1'b0;
            erase_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        nx_reg        <= nh_x;
                        ny_reg        <= nh_y;
                        wall_pend_reg <= nh_wall;
                        self_pend_reg <= 1'b0;
                        grow_pend_reg <= grow_eff;
                        dir_pend_reg  <= eff_dir;
                        scan_ptr_reg  <= scan_first;
                        scan_cnt_reg  <= scan_n;
                    end
                end
                ST_CHECK: begin
                    if (self_match) self_pend_reg <= 1'b1;
                    scan_ptr_reg <= scan_ptr_reg + PW'(1);
                    scan_cnt_reg <= scan_cnt_reg - LW'(1);
                end
                ST_COMMIT: begin
                    done_reg <= 1'b1;
                    if (wall_pend_reg) begin
                        hit_wall_reg <= 1'b1;
                    end else if (self_pend_reg) begin
                        hit_self_reg <= 1'b1;
                    end else begin
                        head_ptr_reg <= head_ptr_reg + PW'(1);
                        head_x_reg   <= nx_reg;
                        head_y_reg   <= ny_reg;
                        last_dir_reg <= dir_pend_reg;
                        if (grow_pend_reg) begin
                            length_reg <= length_reg + LW'(1);
                        end else begin
                            erase_x_reg     <= rd_data_reg[EW-1:Y_W];
                            erase_y_reg     <= rd_data_reg[Y_W-1:0];
                            erase_valid_reg <= 1'b1;
                            tail_ptr_reg    <= tail_ptr_reg + PW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_reg != ST_IDLE);
    assign done        = done_reg;
    assign head_x      = head_x_reg;
    assign head_y      = head_y_reg;
    assign erase_valid = erase_valid_reg;
    assign erase_x     = erase_x_reg;
    assign erase_y     = erase_y_reg;
    assign hit_wall    = hit_wall_reg;
    assign hit_self    = hit_self_reg;
    assign length      = length_reg;

endmodule

// File: tb/tb_snake_body_ring.sv
// ---------------------------------------------------------------------------
// tb_snake_body_ring
// Bench for snake_body_ring: a default-size instance (MAX_LEN=128) driven by
// a constant vector table, directed corner sequences and a random walk
// checked against a queue-based body model, plus a MAX_LEN=4 instance for
// length saturation and pointer wrap.
// ---------------------------------------------------------------------------
module tb_snake_body_ring;

    localparam int X_MAX = 159;
    localparam int Y_MAX = 119;
    localparam int MAXL  = 128;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       step = 1'b0, grow = 1'b0, clear = 1'b0;
    logic [1:0] dir = 2'd1;
    logic       busy, done, erase_valid, hit_wall, hit_self;
    logic [7:0] head_x, erase_x;
    logic [6:0] head_y, erase_y;
    logic [7:0] length;

    logic       step4 = 1'b0, grow4 = 1'b0, clear4 = 1'b0;
    logic [1:0] dir4 = 2'd1;
    logic       busy4, done4, erase_valid4, hit_wall4, hit_self4;
    logic [7:0] head_x4, erase_x4;
    logic [6:0] head_y4, erase_y4;
    logic [2:0] length4;

    always #5 clk = ~clk;

    snake_body_ring dut (
        .clk(clk), .resetn(resetn), .step(step), .grow(grow), .dir(dir),
        .clear(clear), .busy(busy), .done(done), .head_x(head_x),
        .head_y(head_y), .erase_valid(erase_valid), .erase_x(erase_x),
        .erase_y(erase_y), .hit_wall(hit_wall), .hit_self(hit_self),
        .length(length)
    );

    snake_body_ring #(.MAX_LEN(4)) dut4 (
        .clk(clk), .resetn(resetn), .step(step4), .grow(grow4), .dir(dir4),
        .clear(clear4), .busy(busy4), .done(done4), .head_x(head_x4),
        .head_y(head_y4), .erase_valid(erase_valid4), .erase_x(erase_x4),
        .erase_y(erase_y4), .hit_wall(hit_wall4), .hit_self(hit_self4),
        .length(length4)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model: body as queues, tail at [0] ----
    int bx[$];
    int by[$];
    int mdir;
    bit mwall, mself;

    function automatic int opp(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    task automatic m_reset();
        bx = {0};
        by = {0};
        mdir = 1;
        mwall = 0;
        mself = 0;
    endtask

    task automatic m_step(input int d, input int g, output int lat,
                          output int ev, output int erx, output int ery);
        int len, ed, hx, hy, nx, ny, start, n, found;
        bit geff;
        len = bx.size();
        ev = 0; erx = 0; ery = 0;
        ed = d;
        if (len > 1 && d == opp(mdir)) ed = mdir;
        hx = bx[len-1]; hy = by[len-1];
        nx = hx; ny = hy;
        case (ed)
            0: nx = hx - 1;
            1: nx = hx + 1;
            2: ny = hy - 1;
            default: ny = hy + 1;
        endcase
        if (nx < 0 || nx > X_MAX || ny < 0 || ny > Y_MAX) begin
            lat = 2;
            mwall = 1;
            return;
        end
        geff  = (g != 0) && (len < MAXL);
        start = geff ? 0 : 1;           // vacating tail is not an obstacle
        n     = len - start;
        found = -1;
        for (int k = 0; k < n; k++)
            if (found < 0 && bx[start+k] == nx && by[start+k] == ny) found = k;
        if (found >= 0) begin
            lat = found + 3;
            mself = 1;
            return;
        end
        lat = n + 2;
        bx.push_back(nx);
        by.push_back(ny);
        mdir = ed;
        if (!geff) begin
            erx = bx[0]; ery = by[0]; ev = 1;
            void'(bx.pop_front());
            void'(by.pop_front());
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        resetn = 1'b0; step = 1'b0; clear = 1'b0; step4 = 1'b0; clear4 = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        m_reset();
    endtask

    task automatic do_clear();
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        m_reset();
    endtask

    // returns cycles from the step cycle to the done cycle, -1 on timeout
    task automatic run_step(input logic [1:0] d, input logic g,
                            output int lat, output int busy1);
        @(posedge clk); #1;
        step = 1'b1; grow = g; dir = d;
        @(posedge clk); #1;
        step = 1'b0; grow = 1'b0;
        lat = 1; busy1 = busy;
        while (!done && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
        $display("step dir=%0d grow=%0d lat=%0d head=(%0d,%0d) len=%0d ev=%0d erase=(%0d,%0d) wall=%0d self=%0d",
                 d, g, lat, head_x, head_y, length, erase_valid, erase_x, erase_y, hit_wall, hit_self);
    endtask

    task automatic run_step4(input logic [1:0] d, input logic g, output int lat);
        @(posedge clk); #1;
        step4 = 1'b1; grow4 = g; dir4 = d;
        @(posedge clk); #1;
        step4 = 1'b0; grow4 = 1'b0;
        lat = 1;
        while (!done4 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done4) lat = -1;
        $display("step4 dir=%0d grow=%0d lat=%0d head=(%0d,%0d) len=%0d ev=%0d erase=(%0d,%0d)",
                 d, g, lat, head_x4, head_y4, length4, erase_valid4, erase_x4, erase_y4);
    endtask

    // model-checked step
    task automatic check_step(input string tag, input logic [1:0] d, input logic g);
        int elat, eev, erx, ery, lat, b1;
        m_step(int'(d), int'(g), elat, eev, erx, ery);
        run_step(d, g, lat, b1);
        chk({tag, " latency"}, lat, elat);
        chk({tag, " busy"}, b1, 1);
        chk({tag, " head_x"}, head_x, bx[bx.size()-1]);
        chk({tag, " head_y"}, head_y, by[by.size()-1]);
        chk({tag, " length"}, length, bx.size());
        chk({tag, " erase_valid"}, erase_valid, eev);
        if (eev != 0) begin
            chk({tag, " erase_x"}, erase_x, erx);
            chk({tag, " erase_y"}, erase_y, ery);
        end
        chk({tag, " hit_wall"}, hit_wall, mwall);
        chk({tag, " hit_self"}, hit_self, mself);
    endtask

    task automatic step_ignored(input string tag);
        int seen, b1;
        @(posedge clk); #1;
        step = 1'b1; dir = 2'd1;
        @(posedge clk); #1;
        step = 1'b0;
        b1 = busy;
        seen = 0;
        repeat (5) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        $display("ignored step %s busy=%0d dones=%0d", tag, b1, seen);
        chk({tag, " busy"}, b1, 0);
        chk({tag, " done"}, seen, 0);
    endtask

    typedef struct {
        logic [1:0] d;
        logic       g;
        int ex, ey, elen, eev, erx, ery, elat;
    } vec_t;

    vec_t tbl[6];
    vec_t tbl4[5];

    initial begin : main
        int lat, b1, seen;

        // from INIT (0,0): hand-derived expectations
        tbl[0] = '{2'd1, 1'b0, 1, 0, 1, 1, 0, 0, 2};  // plain move, N=0
        tbl[1] = '{2'd3, 1'b1, 1, 1, 2, 0, 0, 0, 3};  // grow, N=1
        tbl[2] = '{2'd3, 1'b1, 1, 2, 3, 0, 0, 0, 4};  // grow, N=2
        tbl[3] = '{2'd1, 1'b0, 2, 2, 3, 1, 1, 0, 4};  // move, N=2
        tbl[4] = '{2'd0, 1'b0, 3, 2, 3, 1, 1, 1, 4};  // reversal filtered
        tbl[5] = '{2'd2, 1'b0, 3, 1, 3, 1, 1, 2, 4};
        // MAX_LEN=4: grow saturates, later grows erase the oldest cell
        tbl4[0] = '{2'd1, 1'b1, 1, 0, 2, 0, 0, 0, 3};
        tbl4[1] = '{2'd1, 1'b1, 2, 0, 3, 0, 0, 0, 4};
        tbl4[2] = '{2'd1, 1'b1, 3, 0, 4, 0, 0, 0, 5};
        tbl4[3] = '{2'd1, 1'b1, 4, 0, 4, 1, 0, 0, 5};
        tbl4[4] = '{2'd1, 1'b1, 5, 0, 4, 1, 1, 0, 5};

        do_reset();
        chk("reset head_x", head_x, 0);
        chk("reset head_y", head_y, 0);
        chk("reset length", length, 1);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset erase_valid", erase_valid, 0);
        chk("reset erase_x", erase_x, 0);
        chk("reset erase_y", erase_y, 0);
        chk("reset hit_wall", hit_wall, 0);
        chk("reset hit_self", hit_self, 0);

        // ---- vector table ----
        for (int i = 0; i < 6; i++) begin
            run_step(tbl[i].d, tbl[i].g, lat, b1);
            chk($sformatf("vec%0d latency", i), lat, tbl[i].elat);
            chk($sformatf("vec%0d head_x", i), head_x, tbl[i].ex);
            chk($sformatf("vec%0d head_y", i), head_y, tbl[i].ey);
            chk($sformatf("vec%0d length", i), length, tbl[i].elen);
            chk($sformatf("vec%0d erase_valid", i), erase_valid, tbl[i].eev);
            if (tbl[i].eev != 0) begin
                chk($sformatf("vec%0d erase_x", i), erase_x, tbl[i].erx);
                chk($sformatf("vec%0d erase_y", i), erase_y, tbl[i].ery);
            end
        end

        // ---- MAX_LEN=4 instance ----
        for (int i = 0; i < 5; i++) begin
            run_step4(tbl4[i].d, tbl4[i].g, lat);
            chk($sformatf("len4 step%0d latency", i), lat, tbl4[i].elat);
            chk($sformatf("len4 step%0d head_x", i), head_x4, tbl4[i].ex);
            chk($sformatf("len4 step%0d length", i), length4, tbl4[i].elen);
            chk($sformatf("len4 step%0d erase_valid", i), erase_valid4, tbl4[i].eev);
            if (tbl4[i].eev != 0) begin
                chk($sformatf("len4 step%0d erase_x", i), erase_x4, tbl4[i].erx);
                chk($sformatf("len4 step%0d erase_y", i), erase_y4, tbl4[i].ery);
            end
        end

        // ---- grow from (5,5) ----
        do_reset();
        for (int i = 0; i < 5; i++) check_step("to55", 2'd3, 1'b0);
        for (int i = 0; i < 5; i++) check_step("to55", 2'd1, 1'b0);
        run_step(2'd1, 1'b1, lat, b1);
        chk("grow55 latency", lat, 3);
        chk("grow55 head_x", head_x, 6);
        chk("grow55 head_y", head_y, 5);
        chk("grow55 length", length, 2);
        chk("grow55 erase_valid", erase_valid, 0);

        // ---- right wall at (159,10) ----
        do_reset();
        for (int i = 0; i < 10; i++) check_step("towall", 2'd3, 1'b0);
        for (int i = 0; i < 159; i++) check_step("towall", 2'd1, 1'b0);
        run_step(2'd1, 1'b0, lat, b1);
        chk("wall latency", lat, 2);
        chk("wall hit_wall", hit_wall, 1);
        chk("wall head_x", head_x, 159);
        chk("wall head_y", head_y, 10);
        chk("wall erase_valid", erase_valid, 0);
        step_ignored("after wall");
        chk("wall still head_x", head_x, 159);
        do_clear();
        chk("clear hit_wall", hit_wall, 0);
        chk("clear head_x", head_x, 0);
        chk("clear head_y", head_y, 0);
        chk("clear length", length, 1);

        // ---- self hit on a 5-cell body ----
        do_reset();
        for (int i = 0; i < 10; i++) check_step("toself", 2'd3, 1'b0);
        for (int i = 0; i < 9; i++) check_step("toself", 2'd1, 1'b0);
        check_step("build", 2'd1, 1'b1);
        check_step("build", 2'd1, 1'b1);
        check_step("build", 2'd3, 1'b1);
        check_step("build", 2'd0, 1'b1);
        run_step(2'd2, 1'b0, lat, b1);   // (10,11) -> (10,10): second-oldest cell
        chk("self latency", lat, 3);
        chk("self hit_self", hit_self, 1);
        chk("self hit_wall", hit_wall, 0);
        chk("self length", length, 5);
        chk("self erase_valid", erase_valid, 0);
        chk("self head_x", head_x, 10);
        chk("self head_y", head_y, 11);
        step_ignored("after self");

        // ---- clear during CHECK aborts the step ----
        do_reset();
        for (int i = 0; i < 6; i++) check_step("abort build", 2'd1, 1'b1);
        @(posedge clk); #1;
        step = 1'b1; grow = 1'b0; dir = 2'd3;
        @(posedge clk); #1;
        step = 1'b0;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        m_reset();
        seen = 0;
        repeat (10) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        $display("abort by clear dones=%0d head=(%0d,%0d) len=%0d", seen, head_x, head_y, length);
        chk("abort done", seen, 0);
        chk("abort head_x", head_x, 0);
        chk("abort length", length, 1);
        run_step(2'd1, 1'b0, lat, b1);
        chk("post-abort latency", lat, 2);
        chk("post-abort head_x", head_x, 1);
        chk("post-abort erase_valid", erase_valid, 1);
        chk("post-abort erase_x", erase_x, 0);
        chk("post-abort erase_y", erase_y, 0);

        // ---- random walk against the model ----
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic [1:0] rd;
            logic       rg;
            if (mwall || mself) do_clear();
            rd = 2'($urandom_range(0, 3));
            rg = ($urandom_range(0, 2) == 0);
            check_step($sformatf("rand%0d", i), rd, rg);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
